// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out converter with a one-word hold
// buffer, so a following word can be emitted without a gap.
//
// Parameters:
//   WIDTH     - parallel word width (2..32)
//   MSB_FIRST - 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
// Ports:
//   clk         - clock, all state updates on the rising edge
//   clear       - synchronous active-high reset
//   d           - parallel data word
//   load_valid  - d holds a word offered for transfer
//   load_ready  - the block accepts d at this edge (= !hold_full)
//   sout        - serial data bit (0 when sout_valid=0)
//   sout_valid  - sout carries a valid bit
//   frame_start - first bit of a word
//   frame_last  - last bit of a word
module piso_serializer #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame_start,
   output logic             frame_last
);

   localparam int unsigned           CntW    = $clog2(WIDTH);
   localparam logic [CntW-1:0]       LastCnt = CntW'(WIDTH - 1);

   typedef enum logic {StIdle, StShift} state_e;

   state_e             state_q;
   logic [WIDTH-1:0]   shreg_q;
   logic [WIDTH-1:0]   hold_q;
   logic               hold_full_q;
   logic [CntW-1:0]    cnt_q;

   logic               accept;
   logic               last_bit;
   logic [WIDTH-1:0]   shreg_shifted;

   assign load_ready = !hold_full_q;
   // clear is folded in so a word offered during reset is never taken.
   assign accept     = load_valid && load_ready && !clear;
   assign last_bit   = (cnt_q == LastCnt);

   always_comb begin
      shreg_shifted = '0;
      if (MSB_FIRST) begin
         shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
         shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q     <= StIdle;
         shreg_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
      end else if (state_q == StIdle) begin
         if (accept) begin
            shreg_q <= d;
            cnt_q   <= '0;
            state_q <= StShift;
         end
      end else begin
         if (last_bit) begin
            cnt_q <= '0;
            // The held word wins over a newly offered one; a fresh word can
            // only be offered here when hold is empty anyway.
            if (hold_full_q) begin
               shreg_q     <= hold_q;
               hold_full_q <= 1'b0;
            end else if (accept) begin
               shreg_q <= d;
            end else begin
               shreg_q <= shreg_shifted;
               state_q <= StIdle;
            end
         end else begin
            shreg_q <= shreg_shifted;
            cnt_q   <= cnt_q + 1'b1;
            if (accept) begin
               hold_q      <= d;
               hold_full_q <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      sout_valid  = (state_q == StShift);
      sout        = sout_valid && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
      frame_start = sout_valid && (cnt_q == '0);
      frame_last  = sout_valid && last_bit;
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer. Instance a is MSB-first,
// instance b is LSB-first; both WIDTH=4.
module tb_piso_serializer;

   logic       clk;
   logic       clear;
   logic [3:0] d_a, d_b;
   logic       lv_a, lv_b;
   logic       ready_a, sout_a, valid_a, fs_a, fl_a;
   logic       ready_b, sout_b, valid_b, fs_b, fl_b;

   int n_checks = 0;
   int n_errors = 0;

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut_a (
      .clk        (clk),
      .clear      (clear),
      .d          (d_a),
      .load_valid (lv_a),
      .load_ready (ready_a),
      .sout       (sout_a),
      .sout_valid (valid_a),
      .frame_start(fs_a),
      .frame_last (fl_a)
   );

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_b (
      .clk        (clk),
      .clear      (clear),
      .d          (d_b),
      .load_valid (lv_b),
      .load_ready (ready_b),
      .sout       (sout_b),
      .sout_valid (valid_b),
      .frame_start(fs_b),
      .frame_last (fl_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic s, input logic v, input logic fs,
                        input logic fl, input logic rdy);
      check({tag, "_sout"}, 32'(sout_a), 32'(s));
      check({tag, "_valid"}, 32'(valid_a), 32'(v));
      check({tag, "_fs"}, 32'(fs_a), 32'(fs));
      check({tag, "_fl"}, 32'(fl_a), 32'(fl));
      check({tag, "_ready"}, 32'(ready_a), 32'(rdy));
   endtask

   task automatic chk_b(input string tag, input logic s, input logic v, input logic fs,
                        input logic fl);
      check({tag, "_sout"}, 32'(sout_b), 32'(s));
      check({tag, "_valid"}, 32'(valid_b), 32'(v));
      check({tag, "_fs"}, 32'(fs_b), 32'(fs));
      check({tag, "_fl"}, 32'(fl_b), 32'(fl));
   endtask

   // Four bits of a word on instance a, MSB first, nothing offered, hold empty.
   task automatic expect_word_a(input string tag, input logic [3:0] w);
      for (int i = 0; i < 4; i++) begin
         chk_a($sformatf("%s_b%0d", tag, i), w[3-i], 1'b1, i == 0, i == 3, 1'b1);
         tick();
      end
   endtask

   // Expected LSB-first stream is given directly as a sequence (bit 0 first).
   task automatic expect_seq_b(input string tag, input logic [3:0] seq);
      for (int i = 0; i < 4; i++) begin
         chk_b($sformatf("%s_b%0d", tag, i), seq[i], 1'b1, i == 0, i == 3);
         tick();
      end
   endtask

   initial begin
      logic [3:0] wa;
      logic [3:0] wb;
      clear = 1'b1;
      d_a   = 4'b1111;
      lv_a  = 1'b1;
      d_b   = 4'b1111;
      lv_b  = 1'b1;

      // Reset held for two edges with load_valid high: nothing accepted.
      tick();
      tick();
      clear = 1'b0;
      lv_a  = 1'b0;
      lv_b  = 1'b0;
      chk_a("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_b("rst_b", 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst_ready_b", 32'(ready_b), 32'd1);
      tick();
      chk_a("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Single word 0011.
      d_a  = 4'b0011;
      lv_a = 1'b1;
      tick();
      lv_a = 1'b0;
      expect_word_a("single", 4'b0011);
      chk_a("single_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back: 0111 then 1011 into hold at the next edge.
      wa   = 4'b0111;
      d_a  = wa;
      lv_a = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk_a($sformatf("b2b_a%0d", i), wa[3-i], 1'b1, i == 0, i == 3, i == 0);
         // 1011 at edge N+1, then junk that must be ignored while hold is full.
         d_a  = (i == 0) ? 4'b1011 : 4'b0000;
         lv_a = 1'b1;
         tick();
      end
      lv_a = 1'b0;
      expect_word_a("b2b_b", 4'b1011);
      chk_a("b2b_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Bypass: 1001, then 1111 offered only at the last-bit edge.
      wa   = 4'b1001;
      d_a  = wa;
      lv_a = 1'b1;
      tick();
      lv_a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_a($sformatf("byp_a%0d", i), wa[3-i], 1'b1, i == 0, i == 3, 1'b1);
         if (i == 3) begin
            d_a  = 4'b1111;
            lv_a = 1'b1;
         end
         tick();
      end
      lv_a = 1'b0;
      expect_word_a("byp_b", 4'b1111);
      chk_a("byp_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Mid-word clear: 1010 with 0001 held, clear after two bits.
      d_a  = 4'b1010;
      lv_a = 1'b1;
      tick();
      chk_a("mid_b0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      d_a = 4'b0001;
      tick();
      lv_a = 1'b0;
      chk_a("mid_b1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk_a("mid_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      // Resume on the first edge after clear drops.
      d_a  = 4'b1011;
      lv_a = 1'b1;
      tick();
      lv_a = 1'b0;
      expect_word_a("mid_new", 4'b1011);
      chk_a("mid_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // LSB-first instance.
      d_b  = 4'b0001;
      lv_b = 1'b1;
      tick();
      lv_b = 1'b0;
      wb   = 4'b0001;  // stream 1,0,0,0 written bit0-first
      expect_seq_b("lsb1", wb);
      chk_b("lsb1_end", 1'b0, 1'b0, 1'b0, 1'b0);
      d_b  = 4'b1010;
      lv_b = 1'b1;
      tick();
      lv_b = 1'b0;
      wb   = 4'b1010;  // stream 0,1,0,1
      expect_seq_b("lsb2", wb);
      chk_b("lsb2_end", 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
